// File: rtl/decision_scheduler.sv
// Decision sequencer for the per-variable assignment bank: picks the next unassigned
// variable, fires it, and backtracks a decision stack on conflict to report SAT/UNSAT.
// Optional feature macro: DECISION_RANDOM_PHASE_EN (LFSR-driven decision phase).
module decision_scheduler #(
  parameter int NVAR = 8,
  parameter int IDXW = $clog2(NVAR),
  parameter int SPW  = $clog2(NVAR + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NVAR-1:0] var_assigned,
  input  logic [NVAR-1:0] var_back,
  input  logic            bcp_done,
  input  logic            conflict,
  output logic [NVAR-1:0] evaluate,
  output logic [NVAR-1:0] complement,
  output logic [NVAR-1:0] assign_fire,
  output logic            random_digit,
  output logic            busy,
  output logic            sat,
  output logic            unsat,
  output logic [15:0]     decision_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_PICK, S_SETUP, S_FIRE, S_WAIT, S_BSETUP, S_BFIRE, S_BCHECK, S_DONE
  } state_e;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            phase;
  } entry_t;

  state_e          state_q;
  logic [SPW-1:0]  sp_q;
  logic [IDXW-1:0] tgt_q;
  logic [NVAR-1:0] eval_q, comp_q, fire_q;
  logic            rdig_q, busy_q, sat_q, unsat_q;
  logic [15:0]     cnt_q, cnt_d;
  entry_t          stack_q [NVAR];

  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic [IDXW-1:0] top_idx;
  entry_t          top;
  logic            phase;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = NVAR - 1; k >= 0; k--) begin
      if (!var_assigned[k]) begin
        pick_idx   = IDXW'(k);
        pick_found = 1'b1;
      end
    end
  end

  assign top_idx = IDXW'(sp_q - SPW'(1));
  assign top     = stack_q[top_idx];
  assign cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef DECISION_RANDOM_PHASE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci taps 16,14,13,11; steps once per PICK visit.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign phase  = lfsr_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lfsr_q <= 16'hACE1;
    else if (state_q == S_PICK) lfsr_q <= lfsr_d;
  end
`else
  assign phase = 1'b0;
`endif

  // NOTE: the stack has no reset; sp_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (state_q == S_PICK && pick_found)
      stack_q[sp_q[IDXW-1:0]] <= '{idx: pick_idx, phase: phase};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      tgt_q   <= '0;
      eval_q  <= '0;
      comp_q  <= '0;
      fire_q  <= '0;
      rdig_q  <= 1'b0;
      busy_q  <= 1'b0;
      sat_q   <= 1'b0;
      unsat_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            sp_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            unsat_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PICK;
          end
        end
        S_PICK: begin
          if (!pick_found) begin
            sat_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            sp_q    <= sp_q + SPW'(1);
            tgt_q   <= pick_idx;
            eval_q  <= NVAR'(1) << pick_idx;
            rdig_q  <= phase;
            cnt_q   <= cnt_d;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          fire_q  <= eval_q;
          state_q <= S_FIRE;
        end
        S_FIRE: begin
          eval_q  <= '0;
          fire_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bcp_done) state_q <= conflict ? S_BSETUP : S_PICK;
        end
        S_BSETUP: begin
          if (sp_q == '0) begin
            unsat_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            tgt_q   <= top.idx;
            comp_q  <= NVAR'(1) << top.idx;
            rdig_q  <= top.phase;
            state_q <= S_BFIRE;
          end
        end
        S_BFIRE: begin
          fire_q  <= comp_q;
          state_q <= S_BCHECK;
        end
        S_BCHECK: begin
          comp_q <= '0;
          fire_q <= '0;
          // back=1 means both phases are spent: discard this level and retry one lower.
          if (var_back[tgt_q]) begin
            sp_q    <= sp_q - SPW'(1);
            state_q <= S_BSETUP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign evaluate     = eval_q;
  assign complement   = comp_q;
  assign assign_fire  = fire_q;
  assign random_digit = rdig_q;
  assign busy         = busy_q;
  assign sat          = sat_q;
  assign unsat        = unsat_q;
  assign decision_cnt = cnt_q;

endmodule

// File: tb/tb_decision_scheduler.sv
// Directed, table-driven bench for decision_scheduler (NVAR=4, default phase-0 build).
module tb_decision_scheduler;

  localparam int NVAR = 4;

  typedef struct packed {
    logic [3:0]  ev;
    logic [3:0]  cp;
    logic [3:0]  fr;
    logic        rd;
    logic        bz;
    logic        st;
    logic        us;
    logic [15:0] cn;
  } outs_t;

  typedef struct {
    string      name;
    logic       start;
    logic [3:0] va;
    logic [3:0] vb;
    logic       bcp;
    logic       cf;
    outs_t      exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NVAR-1:0] var_assigned, var_back;
  logic            bcp_done, conflict;
  logic [NVAR-1:0] evaluate, complement, assign_fire;
  logic            random_digit, busy, sat, unsat;
  logic [15:0]     decision_cnt;
  outs_t           act;

  int n_vec  = 0;
  int n_miss = 0;

  decision_scheduler #(.NVAR(NVAR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .var_assigned(var_assigned), .var_back(var_back),
    .bcp_done(bcp_done), .conflict(conflict),
    .evaluate(evaluate), .complement(complement), .assign_fire(assign_fire),
    .random_digit(random_digit), .busy(busy), .sat(sat), .unsat(unsat),
    .decision_cnt(decision_cnt)
  );

  always #5 clk = ~clk;

  assign act = {evaluate, complement, assign_fire, random_digit, busy, sat, unsat, decision_cnt};

  function automatic outs_t o(logic [3:0] ev, logic [3:0] cp, logic [3:0] fr,
                              logic bz, logic st, logic us, logic [15:0] cn);
    return '{ev: ev, cp: cp, fr: fr, rd: 1'b0, bz: bz, st: st, us: us, cn: cn};
  endfunction

  function automatic vec_t v(string name, logic s, logic [3:0] va, logic [3:0] vb,
                             logic bcp, logic cf, outs_t e);
    vec_t r;
    r.name = name; r.start = s; r.va = va; r.vb = vb; r.bcp = bcp; r.cf = cf; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got ev=%b cp=%b fr=%b rd=%b busy=%b sat=%b unsat=%b cnt=%0d, want ev=%b cp=%b fr=%b rd=%b busy=%b sat=%b unsat=%b cnt=%0d",
               name, act.ev, act.cp, act.fr, act.rd, act.bz, act.st, act.us, act.cn,
               exp.ev, exp.cp, exp.fr, exp.rd, exp.bz, exp.st, exp.us, exp.cn);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, sample at the next negedge.
  task automatic step(input vec_t t);
    start = t.start; var_assigned = t.va; var_back = t.vb; bcp_done = t.bcp; conflict = t.cf;
    @(posedge clk);
    @(negedge clk);
    check(t.name, t.exp);
  endtask

  vec_t tab[$];

  initial begin
    // Straight-line SAT: every fired variable is marked assigned, no conflicts.
    tab.push_back(v("sat_pick0",  1, 4'b0000, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0)));
    tab.push_back(v("sat_setup0", 0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    tab.push_back(v("sat_fire0",  0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1)));
    tab.push_back(v("sat_wait0",  0, 4'b0000, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    tab.push_back(v("sat_pick1",  0, 4'b0001, 4'b0000, 1, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    tab.push_back(v("sat_setup1", 0, 4'b0001, 4'b0000, 0, 0, o(4'b0010, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    tab.push_back(v("sat_fire1",  0, 4'b0001, 4'b0000, 0, 0, o(4'b0010, 4'b0000, 4'b0010, 1, 0, 0, 2)));
    tab.push_back(v("sat_wait1",  0, 4'b0001, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    tab.push_back(v("sat_pick2",  0, 4'b0011, 4'b0000, 1, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    tab.push_back(v("sat_setup2", 0, 4'b0011, 4'b0000, 0, 0, o(4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 3)));
    tab.push_back(v("sat_fire2",  0, 4'b0011, 4'b0000, 0, 0, o(4'b0100, 4'b0000, 4'b0100, 1, 0, 0, 3)));
    tab.push_back(v("sat_wait2",  0, 4'b0011, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 3)));
    tab.push_back(v("sat_pick3",  0, 4'b0111, 4'b0000, 1, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 3)));
    tab.push_back(v("sat_setup3", 0, 4'b0111, 4'b0000, 0, 0, o(4'b1000, 4'b0000, 4'b0000, 1, 0, 0, 4)));
    tab.push_back(v("sat_fire3",  0, 4'b0111, 4'b0000, 0, 0, o(4'b1000, 4'b0000, 4'b1000, 1, 0, 0, 4)));
    tab.push_back(v("sat_wait3",  0, 4'b0111, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4)));
    tab.push_back(v("sat_pick4",  0, 4'b1111, 4'b0000, 1, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4)));
    tab.push_back(v("sat_done",   0, 4'b1111, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4)));
    tab.push_back(v("sat_hold",   0, 4'b1111, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 4)));

    rst = 1'b1; start = 1'b0; var_assigned = '0; var_back = '0; bcp_done = 1'b0; conflict = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_values", o(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));

    foreach (tab[i]) step(tab[i]);

    // All variables already assigned: start clears sat, then SAT with no decisions.
    step(v("alla_pick", 1, 4'b1111, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0)));
    step(v("alla_done", 0, 4'b1111, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0)));

    // Decide vars 0 and 1, then a conflict whose flip of var 1 succeeds.
    step(v("flip_pick0",  1, 4'b0000, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0)));
    step(v("flip_setup0", 0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    step(v("flip_fire0",  0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1)));
    step(v("flip_wait0",  0, 4'b0000, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    step(v("flip_pick1",  0, 4'b0001, 4'b0000, 1, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    step(v("flip_setup1", 0, 4'b0001, 4'b0000, 0, 0, o(4'b0010, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    step(v("flip_fire1",  0, 4'b0001, 4'b0000, 0, 0, o(4'b0010, 4'b0000, 4'b0010, 1, 0, 0, 2)));
    step(v("flip_wait1",  0, 4'b0001, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    step(v("flip_bsetup", 0, 4'b0011, 4'b0000, 1, 1, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    step(v("flip_bfire",  0, 4'b0011, 4'b0000, 0, 0, o(4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 2)));
    step(v("flip_bcheck", 0, 4'b0011, 4'b0000, 0, 0, o(4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 2)));
    step(v("flip_wait",   0, 4'b0011, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));

    // Conflict without bcp_done must be ignored while waiting.
    for (int i = 0; i < 10; i++)
      step(v($sformatf("unqual_conflict_%0d", i), 0, 4'b0011, 4'b0000, 0, 1,
             o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));

    // Every flip attempt reports back=1: pop var 1, then var 0, then UNSAT (proves sp was 2).
    step(v("bt_bsetup1", 0, 4'b0011, 4'b1111, 1, 1, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    step(v("bt_bfire1",  0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0010, 4'b0000, 1, 0, 0, 2)));
    step(v("bt_bcheck1", 0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0010, 4'b0010, 1, 0, 0, 2)));
    step(v("bt_bsetup0", 0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    step(v("bt_bfire0",  0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 2)));
    step(v("bt_bcheck0", 0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0001, 4'b0001, 1, 0, 0, 2)));
    step(v("bt_empty",   0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2)));
    step(v("bt_unsat",   0, 4'b0011, 4'b1111, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 2)));

    // Asynchronous reset while FIRE is driving assign_fire.
    step(v("rf_pick",  1, 4'b0000, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0)));
    step(v("rf_setup", 0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    step(v("rf_fire",  0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1)));
    rst = 1'b1;
    #1;
    check("rf_async_clear", o(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    check("rf_held_idle", o(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    step(v("rf_restart_pick",  1, 4'b0000, 4'b0000, 0, 0, o(4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0)));
    step(v("rf_restart_setup", 0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 1)));
    step(v("rf_restart_fire",  0, 4'b0000, 4'b0000, 0, 0, o(4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
